// File: rtl/loop_seq_pkg.sv
// Shared definitions for the counted-loop sequencer: compare opcodes, FSM states, default width.
package loop_seq_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] CMP_LE = 2'd0;
    localparam logic [1:0] CMP_LT = 2'd1;
    localparam logic [1:0] CMP_GE = 2'd2;
    localparam logic [1:0] CMP_GT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/loop_sequencer_signed_cmp.sv
// Combinational two's-complement compare "a OP b"; operands are treated as signed so
// negative bounds never alias to large unsigned values.
module signed_cmp
    import loop_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             result
);

    always_comb begin
        result = 1'b0;
        case (op)
            CMP_LE:  result = ($signed(a) <= $signed(b));
            CMP_LT:  result = ($signed(a) <  $signed(b));
            CMP_GE:  result = ($signed(a) >= $signed(b));
            CMP_GT:  result = ($signed(a) >  $signed(b));
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/loop_sequencer.sv
// Counted-loop sequencer: for (idx = init; idx OP limit; idx += step), one valid/ready strobe per pass.
// Optional iteration watchdog (timeout output) enabled by defining LOOP_SEQ_WATCHDOG_EN.
module loop_sequencer
    import loop_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] init_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic [1:0]       cmp_op,
    output logic             busy,
    output logic             iter_valid,
    input  logic             iter_ready,
    output logic [WIDTH-1:0] index,
    output logic             done,
    output logic [CNT_W-1:0] trip_count,
    output logic             ovf
`ifdef LOOP_SEQ_WATCHDOG_EN
    ,
    output logic             timeout
`endif
);

`ifdef LOOP_SEQ_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] step_q;
    logic [1:0]       op_q;

    logic             cmp_true;
    logic [WIDTH:0]   next_sum;
    logic             sum_ovf;
    logic             handshake;
    logic [CNT_W-1:0] trip_inc;
    logic             wd_hit;
    logic             wd_stop;

    signed_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a      (index),
        .b      (limit_q),
        .op     (op_q),
        .result (cmp_true)
    );

    // One extra bit makes signed overflow visible as a mismatch of the top two bits.
    assign next_sum  = {index[WIDTH-1], index} + {step_q[WIDTH-1], step_q};
    assign sum_ovf   = next_sum[WIDTH] ^ next_sum[WIDTH-1];
    assign handshake = (state == ISSUE) && iter_valid && iter_ready;
    assign trip_inc  = (&trip_count) ? trip_count : trip_count + CNT_W'(1);
    assign wd_hit    = (trip_inc >= CNT_W'(MAX_ITER));
    assign wd_stop   = WD_EN && wd_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   state_nxt = cmp_true ? ISSUE : FIN;
            ISSUE:   if (handshake) state_nxt = (sum_ovf || wd_stop) ? FIN : CHECK;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q    <= '0;
            step_q     <= '0;
            op_q       <= CMP_LE;
            index      <= '0;
            busy       <= 1'b0;
            iter_valid <= 1'b0;
            done       <= 1'b0;
            trip_count <= '0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        limit_q    <= limit;
                        step_q     <= step;
                        op_q       <= cmp_op;
                        index      <= init_val;
                        trip_count <= '0;
                        ovf        <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                CHECK: begin
                    if (cmp_true) iter_valid <= 1'b1;
                end
                ISSUE: begin
                    if (handshake) begin
                        iter_valid <= 1'b0;
                        trip_count <= trip_inc;
                        if (sum_ovf) begin
                            ovf <= 1'b1;
                        end else if (!wd_stop) begin
                            index <= next_sum[WIDTH-1:0];
                        end
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOOP_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (state == IDLE && start) begin
            timeout <= 1'b0;
        end else if (handshake && wd_hit) begin
            timeout <= 1'b1;
        end
    end
`endif

endmodule
